debug_frame_serializer: RTL

//  Parametrised debug serializer for the cipher core's status counters (key, message, ciphertext).

---
 rtl/dbg_frame_pkg.sv | 32 +++
 rtl/dbg_frame_builder.sv | 34 +++
 rtl/debug_frame_serializer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dbg_frame_pkg.sv
`default_nettype none
// ============================================================================
// dbg_frame_pkg : shared state encoding, default frame delimiters and frame
//                 width helper for the debug frame serializer.
//                 Optional parity bit enabled by macro DBG_FRAME_PARITY_EN.
// Revision      : 1.0
// ============================================================================
package dbg_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] C_START_PAT = 4'b1111;
  localparam logic [3:0] C_END_PAT   = 4'b1001;

`ifdef DBG_FRAME_PARITY_EN
  localparam int C_PARITY_W = 1;
`else
  localparam int C_PARITY_W = 0;
`endif

  function automatic int frame_w(input int start_w, input int key_w,
                                 input int msg_w, input int ct_w,
                                 input int end_w);
    return start_w + key_w + msg_w + ct_w + C_PARITY_W + end_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_frame_builder.sv
`default_nettype none
// ============================================================================
// dbg_frame_builder : combinational frame assembly START|key|msg|ct|[par]|END.
//                     Even parity over key|msg|ct when DBG_FRAME_PARITY_EN.
// Revision          : 1.0
// ============================================================================
module dbg_frame_builder
  import dbg_frame_pkg::*;
#(
  parameter int                 KEY_W     = 4,
  parameter int                 MSG_W     = 7,
  parameter int                 CT_W      = 7,
  parameter int                 START_W   = 4,
  parameter logic [START_W-1:0] START_PAT = C_START_PAT,
  parameter int                 END_W     = 4,
  parameter logic [END_W-1:0]   END_PAT   = C_END_PAT,
  localparam int                FRAME_W   = frame_w(START_W, KEY_W, MSG_W, CT_W, END_W)
) (
  input  logic [KEY_W-1:0]   i_key,
  input  logic [MSG_W-1:0]   i_msg,
  input  logic [CT_W-1:0]    i_ct,
  output logic [FRAME_W-1:0] o_frame
);

`ifdef DBG_FRAME_PARITY_EN
  logic w_parity;
  assign w_parity = ^{i_key, i_msg, i_ct};
  assign o_frame  = {START_PAT, i_key, i_msg, i_ct, w_parity, END_PAT};
`else
  assign o_frame  = {START_PAT, i_key, i_msg, i_ct, END_PAT};
`endif

endmodule
`default_nettype wire

// File: rtl/debug_frame_serializer.sv
`default_nettype none
// ============================================================================
// debug_frame_serializer : snapshots cipher status counters and shifts a
//                          framed word MSB-first with a valid flag.
//                          Optional parity bit via macro DBG_FRAME_PARITY_EN.
// Revision               : 1.0
// ============================================================================
module debug_frame_serializer
  import dbg_frame_pkg::*;
#(
  parameter int                 KEY_W      = 4,
  parameter int                 MSG_W      = 7,
  parameter int                 CT_W       = 7,
  parameter int                 START_W    = 4,
  parameter logic [START_W-1:0] START_PAT  = C_START_PAT,
  parameter int                 END_W      = 4,
  parameter logic [END_W-1:0]   END_PAT    = C_END_PAT,
  parameter int                 GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             debug_en,
  input  logic             single_shot,
  input  logic             trigger,
  input  logic [KEY_W-1:0] key_counter,
  input  logic [MSG_W-1:0] message_counter,
  input  logic [CT_W-1:0]  ciphertext_counter,
  output logic             data_out,
  output logic             data_flag,
  output logic             frame_done,
  output logic             busy
);

  localparam int FRAME_W = frame_w(START_W, KEY_W, MSG_W, CT_W, END_W);
  localparam int CNT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0] C_GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  logic [FRAME_W-1:0] w_frame;

  state_t             r_state,      w_state_nxt;
  logic [FRAME_W-1:0] r_shift,      w_shift_nxt;
  logic [CNT_W-1:0]   r_cnt,        w_cnt_nxt;
  logic [GAP_W-1:0]   r_gap,        w_gap_nxt;
  logic               r_data_out,   w_data_out_nxt;
  logic               r_data_flag,  w_data_flag_nxt;
  logic               r_frame_done, w_frame_done_nxt;
  logic               r_busy,       w_busy_nxt;
  logic               w_run;
  logic               w_go;

  dbg_frame_builder #(
    .KEY_W     (KEY_W),
    .MSG_W     (MSG_W),
    .CT_W      (CT_W),
    .START_W   (START_W),
    .START_PAT (START_PAT),
    .END_W     (END_W),
    .END_PAT   (END_PAT)
  ) u_builder (
    .i_key   (key_counter),
    .i_msg   (message_counter),
    .i_ct    (ciphertext_counter),
    .o_frame (w_frame)
  );

  assign w_run = ena & debug_en;
  assign w_go  = w_run & (~single_shot | trigger);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_gap        <= '0;
      r_data_out   <= 1'b0;
      r_data_flag  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gap        <= w_gap_nxt;
      r_data_out   <= w_data_out_nxt;
      r_data_flag  <= w_data_flag_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_cnt_nxt        = r_cnt;
    w_gap_nxt        = r_gap;
    w_data_out_nxt   = 1'b0;
    w_data_flag_nxt  = 1'b0;
    w_frame_done_nxt = 1'b0;
    if (!w_run) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_go) begin
            w_shift_nxt     = w_frame;
            w_data_out_nxt  = w_frame[FRAME_W-1];
            w_data_flag_nxt = 1'b1;
            w_cnt_nxt       = C_LAST_IDX;
            w_state_nxt     = SHIFT;
          end
        end
        SHIFT: begin
          // r_cnt counts bits still to be presented after the current one
          if (r_cnt == '0) begin
            w_frame_done_nxt = 1'b1;
            if (GAP_CYCLES > 0) begin
              w_gap_nxt   = C_GAP_LOAD;
              w_state_nxt = GAP;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_data_out_nxt  = r_shift[FRAME_W-2];
            w_shift_nxt     = r_shift << 1;
            w_data_flag_nxt = 1'b1;
            w_cnt_nxt       = r_cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (r_gap == '0) begin
            w_state_nxt = IDLE;
          end else begin
            w_gap_nxt = r_gap - GAP_W'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign data_out   = r_data_out;
  assign data_flag  = r_data_flag;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule
`default_nettype wire
